// File: rtl/tm_rx_parser_if.sv
// -----------------------------------------------------------------------------
// tm_rx_parser_if
// Purpose : Bundles the byte-decoder input stream and the time-mark result
//           outputs of tm_rx_parser into one interface.
// Signals : d        received byte, valid while d_rdy=1
//           d_rdy    one-clock strobe, new byte on d
//           d_err    one-clock strobe, decoder framing/parity error
//           tm_det   one-clock pulse, complete time-mark received
//           tm_data  captured payload, first byte in MSBs
//           msg_err  one-clock pulse, message aborted
//           busy     message in progress
// Modports: master - byte source / result sink (decoder + time-base side)
//           slave  - the parser itself
// -----------------------------------------------------------------------------
interface tm_rx_parser_if #(
    parameter int unsigned PAY_LEN = 2
) ();
    logic [7:0]           d;
    logic                 d_rdy;
    logic                 d_err;
    logic                 tm_det;
    logic [8*PAY_LEN-1:0] tm_data;
    logic                 msg_err;
    logic                 busy;

    modport master (
        output d,
        output d_rdy,
        output d_err,
        input  tm_det,
        input  tm_data,
        input  msg_err,
        input  busy
    );

    modport slave (
        input  d,
        input  d_rdy,
        input  d_err,
        output tm_det,
        output tm_data,
        output msg_err,
        output busy
    );
endinterface

// File: rtl/tm_rx_parser.sv
// -----------------------------------------------------------------------------
// tm_rx_parser
// Purpose : Recognises a time-mark message (MARKER, FLAG, PAY_LEN payload bytes)
//           in the decoded byte stream, captures the payload and pulses tm_det.
//           Aborts with a msg_err pulse on decoder error or inter-byte timeout.
// Ports   : i_clk    system clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           bus      tm_rx_parser_if.slave (d, d_rdy, d_err in;
//                    tm_det, tm_data, msg_err, busy out)
// Note    : the interface PAY_LEN must match this module's PAY_LEN.
// -----------------------------------------------------------------------------
module tm_rx_parser #(
    parameter logic [7:0]  MARKER  = 8'hA5,
    parameter logic [7:0]  FLAG    = 8'h3C,
    parameter int unsigned PAY_LEN = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic           i_clk,
    input logic           i_rst_n,
    tm_rx_parser_if.slave bus
);

    localparam int unsigned IDX_W = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned PAY_W = 8 * PAY_LEN;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAY_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGotMark,
        StPayload
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [PAY_W-1:0] r_shift;
    logic [PAY_W-1:0] r_tm_data;
    logic             r_tm_det;
    logic             r_msg_err;
    logic             r_busy;

    // Shift register with the new byte appended at the LSB end; concatenating
    // first keeps this legal for PAY_LEN == 1.
    logic [PAY_W+7:0] w_shift_cat;
    logic [PAY_W-1:0] w_shift_next;
    logic             w_timeout;

    assign w_shift_cat  = {r_shift, bus.d};
    assign w_shift_next = w_shift_cat[PAY_W-1:0];
    assign w_timeout    = (r_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tm_data <= '0;
            r_tm_det  <= 1'b0;
            r_msg_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_tm_det  <= 1'b0;
            r_msg_err <= 1'b0;

            if (r_state == StIdle) begin
                r_cnt <= '0;
                // d_err is deliberately ignored outside a message.
                if (bus.d_rdy && (bus.d == MARKER)) begin
                    r_state <= StGotMark;
                    r_busy  <= 1'b1;
                end
            end else if (bus.d_err) begin
                // Error wins over a coincident byte; tm_data keeps the last good payload.
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_msg_err <= 1'b1;
            end else if (bus.d_rdy) begin
                r_cnt <= '0;
                case (r_state)
                    StGotMark: begin
                        if (bus.d == FLAG) begin
                            r_state <= StPayload;
                            r_idx   <= '0;
                            r_shift <= '0;
                        end else if (bus.d != MARKER) begin
                            // Foreign message type: drop quietly. A repeated MARKER
                            // resyncs by staying here with the timer restarted.
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                    StPayload: begin
                        // MARKER inside the payload is plain data.
                        r_shift <= w_shift_next;
                        if (r_idx == IDX_LAST) begin
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                            r_idx     <= '0;
                            r_tm_data <= w_shift_next;
                            r_tm_det  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_timeout) begin
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_msg_err <= 1'b1;
            end else begin
                // Cannot wrap: reaching TMO_LAST forces the state back to idle.
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.tm_det  = r_tm_det;
    assign bus.tm_data = r_tm_data;
    assign bus.msg_err = r_msg_err;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_tm_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_tm_rx_parser
// Purpose : Directed self-checking bench for tm_rx_parser with MARKER=A5,
//           FLAG=3C, PAY_LEN=2, TIMEOUT=16. Expected payloads are queued when a
//           valid message is driven and popped when tm_det is observed.
// -----------------------------------------------------------------------------
module tb_tm_rx_parser;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned n_det;
    int unsigned n_err;

    logic [15:0] exp_q[$];

    tm_rx_parser_if #(.PAY_LEN(2)) bus ();

    tm_rx_parser #(
        .MARKER (8'hA5),
        .FLAG   (8'h3C),
        .PAY_LEN(2),
        .TIMEOUT(16)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives one byte for exactly one clock and returns at
    // posedge+1 just after the edge that sampled it, so calls chain back-to-back.
    task automatic send_byte(input logic [7:0] b, input logic err);
        bus.d     = b;
        bus.d_rdy = 1'b1;
        bus.d_err = err;
        @(posedge clk);
        #1;
        bus.d_rdy = 1'b0;
        bus.d_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        check("det_err_exclusive", 32'(bus.tm_det & bus.msg_err), 32'd0);
        if (bus.tm_det === 1'b1) begin
            n_det++;
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_tm_data", 32'(bus.tm_data), 32'(exp_q.pop_front()));
        end
        if (bus.msg_err === 1'b1) n_err++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_det     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.d     = 8'h00;
        bus.d_rdy = 1'b0;
        bus.d_err = 1'b0;

        // Reset state
        #1;
        check("rst_tm_det", 32'(bus.tm_det), 32'd0);
        check("rst_msg_err", 32'(bus.msg_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tm_data", 32'(bus.tm_data), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // d_err while idle is ignored
        send_byte(8'h00, 1'b1);
        check("idle_derr_no_msg_err", 32'(bus.msg_err), 32'd0);

        // 1. spaced message, latency one clock after the last byte
        exp_q.push_back(16'h1234);
        send_byte(8'hA5, 1'b0);
        check("t1_busy_after_marker", 32'(bus.busy), 32'd1);
        idle(2);
        send_byte(8'h3C, 1'b0);
        idle(2);
        send_byte(8'h12, 1'b0);
        check("t1_no_early_det", 32'(bus.tm_det), 32'd0);
        idle(2);
        send_byte(8'h34, 1'b0);
        check("t1_tm_det", 32'(bus.tm_det), 32'd1);
        check("t1_tm_data", 32'(bus.tm_data), 32'h1234);
        check("t1_busy_low", 32'(bus.busy), 32'd0);
        idle(1);
        check("t1_det_one_clock", 32'(bus.tm_det), 32'd0);
        check("t1_tm_data_held", 32'(bus.tm_data), 32'h1234);

        // 2. resync on a repeated marker
        exp_q.push_back(16'h5678);
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        check("t2_busy_resync", 32'(bus.busy), 32'd1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        check("t2_tm_det", 32'(bus.tm_det), 32'd1);
        check("t2_tm_data", 32'(bus.tm_data), 32'h5678);
        idle(2);

        // 3. foreign message type aborts silently
        send_byte(8'hA5, 1'b0);
        send_byte(8'h7E, 1'b0);
        check("t3_no_msg_err", 32'(bus.msg_err), 32'd0);
        check("t3_busy_low", 32'(bus.busy), 32'd0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("t3_no_det", 32'(bus.tm_det), 32'd0);
        check("t3_tm_data_kept", 32'(bus.tm_data), 32'h5678);
        idle(2);

        // 4. inter-byte timeout: abort on the 16th idle clock
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h9A, 1'b0);
        idle(15);
        check("t4_no_early_timeout", 32'(bus.msg_err), 32'd0);
        check("t4_busy_before_timeout", 32'(bus.busy), 32'd1);
        idle(1);
        check("t4_msg_err", 32'(bus.msg_err), 32'd1);
        check("t4_busy_low", 32'(bus.busy), 32'd0);
        check("t4_tm_data_kept", 32'(bus.tm_data), 32'h5678);
        idle(1);
        check("t4_msg_err_one_clock", 32'(bus.msg_err), 32'd0);

        // 5. d_err coincident with the last payload byte
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b1);
        check("t5_msg_err", 32'(bus.msg_err), 32'd1);
        check("t5_no_det", 32'(bus.tm_det), 32'd0);
        check("t5_tm_data_kept", 32'(bus.tm_data), 32'h5678);
        idle(1);
        exp_q.push_back(16'hDEAD);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        check("t5_recover_det", 32'(bus.tm_det), 32'd1);
        check("t5_recover_data", 32'(bus.tm_data), 32'hDEAD);
        idle(1);

        // MARKER value inside the payload is data
        exp_q.push_back(16'hA55A);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("marker_in_payload", 32'(bus.tm_data), 32'hA55A);
        idle(1);

        // 6. reset mid-payload, then two back-to-back messages
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h77, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_tm_data", 32'(bus.tm_data), 32'd0);
        check("t6_rst_tm_det", 32'(bus.tm_det), 32'd0);
        check("t6_rst_msg_err", 32'(bus.msg_err), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back(16'h0102);
        exp_q.push_back(16'h0304);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        check("t6_first_det", 32'(bus.tm_det), 32'd1);
        check("t6_first_data", 32'(bus.tm_data), 32'h0102);
        send_byte(8'hA5, 1'b0);
        check("t6_b2b_marker_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("t6_second_det", 32'(bus.tm_det), 32'd1);
        check("t6_second_data", 32'(bus.tm_data), 32'h0304);
        idle(3);

        // Totals
        check("total_tm_det", 32'(n_det), 32'd6);
        check("total_msg_err", 32'(n_err), 32'd2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
